// File: rtl/mem_arbiter.sv
// Arbiter that lets the fetch (IF) and load/store (D) ports share one single-port memory.
// It serves one access at a time, uses round-robin on ties, and ends unacknowledged accesses with a watchdog.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_if_req,
  input  logic [ADDR_WIDTH-1:0] i_if_addr,
  input  logic                  i_d_req,
  input  logic                  i_d_we,
  input  logic [ADDR_WIDTH-1:0] i_d_addr,
  input  logic [DATA_WIDTH-1:0] i_d_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_if_valid,
  output logic                  o_d_valid,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic SRV_IF = 1'b0;
  localparam logic SRV_D  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY_IF = 2'd1,
    S_BUSY_D  = 2'd2,
    S_RESP    = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  last_q, last_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  if_valid_q, if_valid_d;
  logic                  d_valid_q, d_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  grant_if_c, grant_d_c;

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q     <= S_IDLE;
      wd_q        <= '0;
      last_q      <= SRV_D;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    grant_if_c  = 1'b0;
    grant_d_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_req_d  = 1'b0;
        // On a tie, the port that was not served last wins
        grant_if_c = i_if_req && (!i_d_req || (last_q == SRV_D));
        grant_d_c  = i_d_req && !grant_if_c;
        if (grant_if_c) begin
          state_d     = S_BUSY_IF;
          wd_d        = '0;
          last_d      = SRV_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_if_addr;
          mem_wdata_d = '0;
        end else if (grant_d_c) begin
          state_d     = S_BUSY_D;
          wd_d        = '0;
          last_d      = SRV_D;
          mem_req_d   = 1'b1;
          mem_we_d    = i_d_we;
          mem_addr_d  = i_d_addr;
          mem_wdata_d = i_d_wdata;
        end
      end

      S_BUSY_IF, S_BUSY_D: begin
        // An ack wins over a timeout that falls in the same cycle
        if (i_mem_ack) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          rdata_d    = mem_we_q ? '0 : i_mem_rdata;
          err_d      = 1'b0;
          if_valid_d = (state_q == S_BUSY_IF);
          d_valid_d  = (state_q == S_BUSY_D);
        end else if (wd_q == WD_LAST) begin
          state_d    = S_RESP;
          mem_req_d  = 1'b0;
          rdata_d    = '0;
          err_d      = 1'b1;
          if_valid_d = (state_q == S_BUSY_IF);
          d_valid_d  = (state_q == S_BUSY_D);
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_RESP: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_if_valid  = if_valid_q;
  assign o_d_valid   = d_valid_q;
  assign o_rdata     = rdata_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter.
// Inputs are driven and outputs are sampled 1ns after each rising clock edge.
module tb_mem_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          arst;
  logic          if_req, d_req, d_we, mem_ack;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          mem_req, mem_we, if_valid, d_valid, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(clk), .i_arst(arst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_if_valid(if_valid), .o_d_valid(d_valid), .o_rdata(rdata), .o_err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1; if_req = 0; d_req = 0; d_we = 0; mem_ack = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick(); tick();
    total++; if ({mem_req, mem_we, if_valid, d_valid, err} !== 5'b0) begin bad++; $display("FAIL reset_ctl got=%b exp=00000", {mem_req, mem_we, if_valid, d_valid, err}); end
    total++; if (mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin bad++; $display("FAIL reset_data addr=%h wdata=%h rdata=%h exp=0", mem_addr, mem_wdata, rdata); end
    arst = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    if_req = 1; if_addr = 10'h010;
    tick();
    total++; if (mem_req !== 1 || mem_we !== 0 || mem_addr !== 10'h010) begin bad++; $display("FAIL if_busy req=%b we=%b addr=%h exp=1 0 010", mem_req, mem_we, mem_addr); end
    if_req = 0; mem_ack = 1; mem_rdata = 32'h0000_0513;
    tick();
    mem_ack = 0; mem_rdata = 32'h1111_1111;
    total++; if (if_valid !== 1 || d_valid !== 0 || mem_req !== 0) begin bad++; $display("FAIL if_valid ifv=%b dv=%b req=%b exp=1 0 0", if_valid, d_valid, mem_req); end
    total++; if (rdata !== 32'h0000_0513 || err !== 0) begin bad++; $display("FAIL if_rdata got=%h err=%b exp=00000513 0", rdata, err); end
    tick();
    total++; if (if_valid !== 0 || rdata !== 32'h0000_0513) begin bad++; $display("FAIL if_hold ifv=%b rdata=%h exp=0 00000513", if_valid, rdata); end
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    arst = 1; tick(); arst = 0;
    if_req = 1; if_addr = 10'h100; d_req = 1; d_we = 0; d_addr = 10'h204; d_wdata = 32'h5555_AAAA;
    for (int g = 0; g < 4; g++) begin
      exp_addr = (g % 2 == 0) ? 10'h100 : 10'h204;
      exp_data = 32'hA000_0000 + DW'(g);
      tick();
      total++; if (mem_req !== 1 || mem_addr !== exp_addr || mem_we !== 0) begin bad++; $display("FAIL rr_grant%0d req=%b addr=%h we=%b exp=1 %h 0", g, mem_req, mem_addr, mem_we, exp_addr); end
      mem_ack = 1; mem_rdata = exp_data;
      tick();
      mem_ack = 0;
      total++; if (if_valid !== (g % 2 == 0) || d_valid !== (g % 2 == 1) || rdata !== exp_data) begin bad++; $display("FAIL rr_resp%0d ifv=%b dv=%b rdata=%h exp_rdata=%h", g, if_valid, d_valid, rdata, exp_data); end
      tick();
    end
    if_req = 0; d_req = 0;
    tick();
  endtask

  task automatic test_d_write();
    d_req = 1; d_we = 1; d_addr = 10'h020; d_wdata = 32'hDEAD_BEEF;
    tick();
    d_req = 0; d_we = 0; d_addr = 10'h3FF; d_wdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_req !== 1 || mem_we !== 1 || mem_addr !== 10'h020 || mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dw_busy%0d req=%b we=%b addr=%h wdata=%h", i, mem_req, mem_we, mem_addr, mem_wdata); end
      if (i == 2) begin mem_ack = 1; mem_rdata = 32'h1234_5678; end
      tick();
    end
    mem_ack = 0;
    total++; if (d_valid !== 1 || if_valid !== 0 || rdata !== '0 || err !== 0) begin bad++; $display("FAIL dw_resp dv=%b ifv=%b rdata=%h err=%b exp=1 0 0 0", d_valid, if_valid, rdata, err); end
    tick();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    if_req = 1; if_addr = 10'h040; mem_rdata = 32'hFFFF_FFFF;
    tick();
    if_req = 0;
    for (int i = 0; i < 40 && mem_req === 1; i++) begin
      cnt++;
      tick();
    end
    total++; if (cnt !== 16) begin bad++; $display("FAIL to_len got=%0d exp=16", cnt); end
    total++; if (if_valid !== 1 || err !== 1 || rdata !== '0) begin bad++; $display("FAIL to_resp ifv=%b err=%b rdata=%h exp=1 1 0", if_valid, err, rdata); end
    tick();
    if_req = 1; if_addr = 10'h044;
    tick();
    if_req = 0; mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 0;
    total++; if (if_valid !== 1 || err !== 0 || rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL to_after ifv=%b err=%b rdata=%h exp=1 0 cafef00d", if_valid, err, rdata); end
    tick();
  endtask

  task automatic test_ack_on_timeout();
    if_req = 1; if_addr = 10'h080;
    tick();
    if_req = 0;
    for (int i = 0; i < 15; i++) tick();
    total++; if (mem_req !== 1) begin bad++; $display("FAIL aot_busy req=%b exp=1", mem_req); end
    mem_ack = 1; mem_rdata = 32'hA5A5_1234;
    tick();
    mem_ack = 0;
    total++; if (if_valid !== 1 || err !== 0 || rdata !== 32'hA5A5_1234) begin bad++; $display("FAIL aot_resp ifv=%b err=%b rdata=%h exp=1 0 a5a51234", if_valid, err, rdata); end
    tick();
  endtask

  task automatic test_reset_mid();
    if_req = 1; if_addr = 10'h0C0;
    tick();
    if_req = 0;
    tick();
    total++; if (mem_req !== 1) begin bad++; $display("FAIL rm_busy req=%b exp=1", mem_req); end
    arst = 1;
    tick();
    arst = 0;
    total++; if ({mem_req, mem_we, if_valid, d_valid, err} !== 5'b0 || mem_addr !== '0 || rdata !== '0) begin bad++; $display("FAIL rm_outs ctl=%b addr=%h rdata=%h exp=0", {mem_req, mem_we, if_valid, d_valid, err}, mem_addr, rdata); end
    mem_ack = 1; mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (if_valid !== 0 || d_valid !== 0 || mem_req !== 0) begin bad++; $display("FAIL rm_late%0d ifv=%b dv=%b req=%b exp=0 0 0", i, if_valid, d_valid, mem_req); end
    end
    mem_ack = 0;
    if_req = 1; if_addr = 10'h0C4; d_req = 1; d_we = 0; d_addr = 10'h2C8;
    tick();
    if_req = 0; d_req = 0;
    total++; if (mem_req !== 1 || mem_addr !== 10'h0C4) begin bad++; $display("FAIL rm_tie req=%b addr=%h exp=1 0c4", mem_req, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h0000_BEEF;
    tick();
    mem_ack = 0;
    total++; if (if_valid !== 1 || d_valid !== 0 || rdata !== 32'h0000_BEEF) begin bad++; $display("FAIL rm_tie_resp ifv=%b dv=%b rdata=%h exp=1 0 0000beef", if_valid, d_valid, rdata); end
    tick();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_round_robin();
    test_d_write();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
